// File: rtl/pixel_sink.sv
// pixel_sink: receives sprite pixel writes, queues them in a small FIFO, bounds-checks
//   each one and writes it to the framebuffer port; can also sweep the whole screen to BG_COLOUR.
// Latency: push at edge N into an empty FIFO while idle -> fb write registered at edge N+1.
// Backpressure: ready = !full (combinational); a writeEn while !ready is dropped.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   writeEn/x_in/y_in/colour, ready   pixel write request and FIFO-not-full
//   clear, clear_busy     start clear sweep (sampled when idle), sweep in progress
//   fb_wren/fb_addr/fb_data           registered framebuffer write port
//   drop_cnt              out-of-range pop counter, only when PIXEL_SINK_DROP_CNT_EN is defined
module pixel_sink #(
    parameter int         WIDTH      = 160,
    parameter int         HEIGHT     = 120,
    parameter int         ADDR_W     = 15,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEn,
    input  logic [9:0]        x_in,
    input  logic [9:0]        y_in,
    input  logic [2:0]        colour,
    output logic              ready,
    input  logic              clear,
    output logic              clear_busy,
    output logic              fb_wren,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data
`ifdef PIXEL_SINK_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] colour;
    } pix_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    pix_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic [PTR_W:0]   cnt_d;

    state_t            state_q;
    logic              fb_wren_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [2:0]        fb_data_q;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    pix_t              head;
    logic              head_ok;
    logic [ADDR_W-1:0] head_addr;

    assign full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign ready = !full;

    // Acceptance uses the pre-edge full flag, so a same-edge pop never frees a slot early.
    assign push = writeEn && !full;
    // A clear request takes priority over draining in the same cycle.
    assign pop  = (state_q == S_IDLE) && !clear && !empty;

    assign head      = mem_q[rd_ptr_q];
    assign head_ok   = (head.x < 10'(WIDTH)) && (head.y < 10'(HEIGHT));
    assign head_addr = ADDR_W'(32'(head.y) * WIDTH + 32'(head.x));

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {x_in, y_in, colour};
        end
    end

    // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    // Control FSM with registered framebuffer outputs. During the sweep fb_addr_q
    // itself is the sweep counter: it starts at 0 on entry and steps once per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            fb_wren_q <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        state_q   <= S_CLEAR;
                        fb_wren_q <= 1'b1;
                        fb_addr_q <= '0;
                        fb_data_q <= BG_COLOUR;
                    end else if (pop) begin
                        // Out-of-range entries are consumed without a write.
                        fb_wren_q <= head_ok;
                        if (head_ok) begin
                            fb_addr_q <= head_addr;
                            fb_data_q <= head.colour;
                        end
                    end else begin
                        fb_wren_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (fb_addr_q == LAST_ADDR) begin
                        state_q   <= S_IDLE;
                        fb_wren_q <= 1'b0;
                    end else begin
                        fb_wren_q <= 1'b1;
                        fb_addr_q <= fb_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    fb_wren_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy = (state_q == S_CLEAR);
    assign fb_wren    = fb_wren_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;

`ifdef PIXEL_SINK_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (pop && !head_ok && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_sink.sv
// Testbench for pixel_sink: directed scenarios plus random traffic, every cycle
// compared against a queue-based behavioural model of the pixel sink.
module tb_pixel_sink;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int DEPTH = 8;
    localparam int NPIX  = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [9:0]  xi = '0;
    logic [9:0]  yi = '0;
    logic [2:0]  ci = '0;
    logic        clr = 1'b0;
    logic        ready;
    logic        clear_busy;
    logic        fb_wren;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
`ifdef PIXEL_SINK_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    pixel_sink dut (
        .clk        (clk),
        .reset      (reset),
        .writeEn    (we),
        .x_in       (xi),
        .y_in       (yi),
        .colour     (ci),
        .ready      (ready),
        .clear      (clr),
        .clear_busy (clear_busy),
        .fb_wren    (fb_wren),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data)
`ifdef PIXEL_SINK_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pending pixels as a queue, sweep as a plain index.
    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t pend[$];
    bit   m_clear = 0;
    int   m_sweep = 0;
    bit   e_wren = 0;
    int   e_addr = 0;
    int   e_data = 0;
    int   m_drops = 0;

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        pend.delete();
        m_clear = 0;
        m_sweep = 0;
        e_wren  = 0;
        e_addr  = 0;
        e_data  = 0;
        m_drops = 0;
    endfunction

    // One clock edge of behaviour, using the inputs applied before the edge.
    function automatic void model_edge();
        bit   acc;
        pix_t p;
        acc = we && (pend.size() < DEPTH);
        if (m_clear) begin
            if (m_sweep == NPIX - 1) begin
                m_clear = 0;
                e_wren  = 0;
            end else begin
                m_sweep++;
                e_wren = 1;
                e_addr = m_sweep;
                e_data = 0;
            end
        end else if (clr) begin
            m_clear = 1;
            m_sweep = 0;
            e_wren  = 1;
            e_addr  = 0;
            e_data  = 0;
        end else if (pend.size() > 0) begin
            p = pend.pop_front();
            if (p.x < W && p.y < H) begin
                e_wren = 1;
                e_addr = p.y * W + p.x;
                e_data = p.c;
            end else begin
                e_wren = 0;
                if (m_drops < 65535) m_drops++;
            end
        end else begin
            e_wren = 0;
        end
        if (acc) pend.push_back('{int'(xi), int'(yi), int'(ci)});
    endfunction

    task automatic check_outputs();
        chk("fb_wren", {31'b0, fb_wren}, {31'b0, e_wren});
        if (e_wren) begin
            chk("fb_addr", {17'b0, fb_addr}, e_addr);
            chk("fb_data", {29'b0, fb_data}, e_data);
        end
        chk("ready", {31'b0, ready}, (pend.size() < DEPTH) ? 32'd1 : 32'd0);
        chk("clear_busy", {31'b0, clear_busy}, {31'b0, m_clear});
`ifdef PIXEL_SINK_DROP_CNT_EN
        chk("drop_cnt", {16'b0, drop_cnt}, m_drops);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_pix(input int x, input int y, input int c);
        we = 1'b1;
        xi = 10'(x);
        yi = 10'(y);
        ci = 3'(c);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wren"}, {31'b0, fb_wren}, 0);
        chk({tag, "_addr"}, {17'b0, fb_addr}, 0);
        chk({tag, "_data"}, {29'b0, fb_data}, 0);
        chk({tag, "_ready"}, {31'b0, ready}, 1);
        chk({tag, "_busy"}, {31'b0, clear_busy}, 0);
`ifdef PIXEL_SINK_DROP_CNT_EN
        chk({tag, "_drop"}, {16'b0, drop_cnt}, 0);
`endif
    endtask

    initial begin
        int busy_cnt;
        int wr_cnt;

        // Reset state
        #1;
        check_reset_vals("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // 1: single pixel, two-edge latency
        set_pix(5, 3, 7);
        tick();
        chk("t1_no_early_wren", {31'b0, fb_wren}, 0);
        we = 1'b0;
        tick();
        chk("t1_wren", {31'b0, fb_wren}, 1);
        chk("t1_addr", {17'b0, fb_addr}, 485);
        chk("t1_data", {29'b0, fb_data}, 7);
        tick();
        chk("t1_wren_off", {31'b0, fb_wren}, 0);

        // 2: out-of-range pixels dropped, corner pixel written
        set_pix(160, 0, 5);
        tick();
        set_pix(0, 120, 6);
        tick();
        set_pix(159, 119, 2);
        tick();
        chk("t2_drop1_wren", {31'b0, fb_wren}, 0);
        we = 1'b0;
        tick();
        chk("t2_corner_wren", {31'b0, fb_wren}, 1);
        chk("t2_corner_addr", {17'b0, fb_addr}, 19199);
`ifdef PIXEL_SINK_DROP_CNT_EN
        chk("t2_drop_cnt", {16'b0, drop_cnt}, 2);
`endif
        repeat (2) tick();

        // 3: clear sweep while 10 pixels are pushed back-to-back
        clr = 1'b1;
        tick();
        clr = 1'b0;
        busy_cnt = int'(clear_busy);
        for (int i = 0; i < 10; i++) begin
            set_pix($urandom_range(W - 1), $urandom_range(H - 1), $urandom_range(7));
            tick();
            if (clear_busy) busy_cnt++;
            if (i == 7) chk("t3_ready_after8", {31'b0, ready}, 0);
        end
        we = 1'b0;
        for (int i = 0; i < NPIX + 100 && m_clear; i++) begin
            tick();
            if (clear_busy) busy_cnt++;
        end
        chk("t3_busy_cycles", busy_cnt, NPIX);
        repeat (12) tick();

        // 4: burst of 20 in-range pixels while idle
        wr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            set_pix($urandom_range(W - 1), $urandom_range(H - 1), $urandom_range(7));
            tick();
            if (fb_wren) wr_cnt++;
        end
        we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fb_wren) wr_cnt++;
        end
        chk("t4_write_count", wr_cnt, 20);

        // 5: reset in the middle of a sweep with 3 entries queued
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pix($urandom_range(W - 1), $urandom_range(H - 1), $urandom_range(7));
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 2000 && e_addr != 1000; i++) tick();
        chk("t5_at_addr1000", {17'b0, fb_addr}, 1000);
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_vals("t5_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) tick();

        // 6: clear requested while draining; remaining pixels follow the sweep
        set_pix(10, 10, 1);
        tick();
        set_pix(11, 10, 2);
        tick();
        set_pix(12, 10, 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_pix(13, 10, 4);
        tick();
        we = 1'b0;
        for (int i = 0; i < NPIX + 100 && m_clear; i++) tick();
        chk("t6_sweep_done", {31'b0, clear_busy}, 0);
        tick();
        chk("t6_first_after", {17'b0, fb_addr}, 10 * W + 11);
        repeat (4) tick();

        // Random traffic including out-of-range coordinates and backpressure-free bursts
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(1));
            xi = 10'($urandom_range(170));
            yi = 10'($urandom_range(130));
            ci = 3'($urandom_range(7));
            tick();
        end
        we = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
